// File: rtl/my_mux_n_way_rr.sv
// my_mux_n_way_rr
//   Merges CHANNELS valid/ready input streams onto one registered output.
//   The input channel is picked in one of two ways:
//     - fixed mode: the channel given by sel
//     - round-robin mode: the next valid channel after the last one granted
//   The output stage holds one word. It can load a new word in the same
//   cycle that the consumer drains the old one.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_data          CHANNELS packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid         per-channel valid
//   in_ready         per-channel accept strobe, at most one bit high (combinational)
//   mode             0 = fixed (use sel), 1 = round-robin
//   sel              channel index used in fixed mode
//   out_data         registered selected word
//   out_chan         index of the channel that supplied out_data
//   out_valid        the output register holds a word
//   out_ready        the consumer accepts out_data
module my_mux_n_way_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]            grant;
  logic [SEL_W-1:0]               gnt_idx;
  logic [WIDTH-1:0]               gnt_data;
  logic                           gnt_any;
  logic [SEL_W-1:0]               rr_ptr;
  logic                           can_accept;
  logic                           xfer_in;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // One-hot grant. The index and the data are resolved in the same search,
  // so an out-of-range sel simply matches no channel.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    gnt_any  = 1'b0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SEL_W'(i);
          gnt_data = ch_data[i];
          gnt_any  = 1'b1;
        end
      end
    end else begin
      // Priority starts just after rr_ptr and wraps. Offset CHANNELS
      // lands back on rr_ptr itself, so it has the lowest priority.
      for (int k = 1; k <= CHANNELS; k++) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!gnt_any && in_valid[i] && i == (int'(rr_ptr) + k) % CHANNELS) begin
            grant[i] = 1'b1;
            gnt_idx  = SEL_W'(i);
            gnt_data = ch_data[i];
            gnt_any  = 1'b1;
          end
        end
      end
    end
  end

  // rst_n gates the accept path, so no strobe is raised while in reset.
  assign can_accept = rst_n && (!out_valid || out_ready);
  assign in_ready   = grant & {CHANNELS{can_accept}};
  assign xfer_in    = gnt_any && can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
      rr_ptr    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_my_mux_n_way_rr.sv
module tb_my_mux_n_way_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // 4 x 16 instance
  logic [63:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode, out_valid, out_ready;
  logic [1:0]  sel, out_chan;
  logic [15:0] out_data;

  // 3 x 8 instance
  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_ready;
  logic        d3_mode, d3_out_valid, d3_out_ready;
  logic [1:0]  d3_sel, d3_out_chan;
  logic [7:0]  d3_out_data;

  always #5 clk = ~clk;

  my_mux_n_way_rr #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  my_mux_n_way_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data),
    .out_chan(d3_out_chan), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_s[4] = '{1, 3, 1, 3};

    // reset with random inputs
    rst_n        = 1'b0;
    in_data      = {$urandom, $urandom};
    in_valid     = 4'hF;
    mode         = 1'($urandom);
    sel          = 2'($urandom);
    out_ready    = 1'($urandom);
    d3_in_data   = 24'($urandom);
    d3_in_valid  = 3'b111;
    d3_mode      = 1'b1;
    d3_sel       = 2'd0;
    d3_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_chan",  32'(out_chan), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_ready3", 32'(d3_in_ready), 0);
    d3_in_valid = 3'b000;

    // round-robin, all valid: strict 0,1,2,3 cycle from channel 0
    in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    in_valid  = 4'hF;
    mode      = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr4_chan", 32'(out_chan), 32'(k % 4));
      chk("rr4_data", 32'(out_data), 32'h0000A000 + 32'(k % 4));
      chk("rr4_valid", 32'(out_valid), 1);
    end

    // only channels 1 and 3 valid
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_sparse_chan", 32'(out_chan), 32'(exp_s[k]));
    end

    // fixed mode, sel=2
    mode = 1'b0;
    sel  = 2'd2;
    in_data[47:32] = 16'hBEEF;
    in_valid = 4'hF;
    #1 chk("fix_ready", 32'(in_ready), 32'b0100);
    step();
    chk("fix_data", 32'(out_data), 32'hBEEF);
    chk("fix_chan", 32'(out_chan), 2);
    // sel points at an idle channel: nothing granted, output drains
    sel = 2'd3;
    in_valid = 4'b0111;
    #1 chk("fix_idle_ready", 32'(in_ready), 0);
    step();
    chk("fix_idle_valid", 32'(out_valid), 0);
    chk("fix_idle_data_hold", 32'(out_data), 32'hBEEF);

    // backpressure: load 1234 from ch1 (rr_ptr -> 1), then stall in RR mode
    sel = 2'd1;
    in_data[31:16] = 16'h1234;
    in_valid = 4'hF;
    step();
    chk("bp_load", 32'(out_data), 32'h1234);
    out_ready = 1'b0;
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(in_ready), 0);
      step();
      chk("bp_data", 32'(out_data), 32'h1234);
      chk("bp_chan", 32'(out_chan), 1);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_chan", 32'(out_chan), 2);
    chk("bp_release_data", 32'(out_data), 32'hBEEF);

    // drain and fill in the same edge
    mode = 1'b0;
    sel  = 2'd0;
    in_data[15:0] = 16'h00AA;
    in_valid = 4'b0001;
    #1 chk("df_ready", 32'(in_ready), 32'b0001);
    step();
    chk("df_valid", 32'(out_valid), 1);
    chk("df_data", 32'(out_data), 32'h00AA);
    chk("df_chan", 32'(out_chan), 0);

    // mid-stream asynchronous reset
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_ready", 32'(in_ready), 0);
    mode = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    #1 rst_n = 1'b1;
    step();
    chk("mrst_rr0", 32'(out_chan), 0);
    step();
    chk("mrst_rr1", 32'(out_chan), 1);

    // 3-channel instance: cycle 0,1,2 and wrap
    d3_in_data  = {8'h12, 8'h11, 8'h10};
    d3_in_valid = 3'b111;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("rr3_chan", 32'(d3_out_chan), 32'(k % 3));
      chk("rr3_data", 32'(d3_out_data), 32'h10 + 32'(k % 3));
    end
    // out-of-range sel grants nothing
    d3_mode = 1'b0;
    d3_sel  = 2'd3;
    #1 chk("rr3_sel_oor", 32'(d3_in_ready), 0);
    step();
    chk("rr3_oor_drain", 32'(d3_out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
